// File: rtl/mag_cmp_seq.sv
// Multi-cycle magnitude comparator: walks the operands SLICE bits per cycle, MSB first,
// and stops at the first differing slice. Result {gt, eq, lt} is held until the next compare.
module mag_cmp_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic [2:0]       out
);

   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]    IDX_TOP  = IW'(N - 1);
   localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMP  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] flip;
   logic [31:0]      sh;
   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;

   // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
   assign flip = signed_mode ? SIGN_BIT : '0;

   assign sh = 32'(idx) * 32'(SLICE);
   assign sa = SLICE'(ra >> sh);
   assign sb = SLICE'(rb >> sh);

   assign busy = (state == CMP);
   assign done = (state == DONE);

   // NOTE: non-blocking assignments keep every register update here independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= IDX_TOP;
         ra    <= '0;
         rb    <= '0;
         out   <= 3'b000;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  ra    <= a ^ flip;
                  rb    <= b ^ flip;
                  idx   <= IDX_TOP;
                  state <= CMP;
               end else begin
                  state <= IDLE;
               end
            end
            CMP: begin
               if (sa != sb) begin
                  out   <= {sa > sb, 1'b0, sa < sb};
                  state <= DONE;
               end else if (idx == '0) begin
                  out   <= 3'b010;
                  state <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Bench for mag_cmp_seq: several parameter sets run side by side, each checked every cycle
// against a timing-level model, with directed literal cases on the 16/4 instance.
module tb_mag_cmp_seq;

   localparam int NCFG = 5;
   localparam int CW [NCFG] = '{16, 16, 16, 32, 8};
   localparam int CS [NCFG] = '{4, 1, 16, 8, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit fin_v [NCFG];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain signed/unsigned comparison, and k = position of the first differing slice.
   function automatic void ref_cmp(input logic [63:0] x, input logic [63:0] y, input int w,
                                   input int s, input bit sg, output logic [2:0] o, output int k);
      logic [63:0] ux, uy, smask;
      longint      sx, sy;
      bit          gt, lt, found;
      int          n;
      ux = x & ((64'd1 << w) - 1);
      uy = y & ((64'd1 << w) - 1);
      if (sg) begin
         sx = $signed(ux << (64 - w)) >>> (64 - w);
         sy = $signed(uy << (64 - w)) >>> (64 - w);
         gt = sx > sy;
         lt = sx < sy;
      end else begin
         gt = ux > uy;
         lt = ux < uy;
      end
      o = gt ? 3'b100 : (lt ? 3'b001 : 3'b010);
      n = w / s;
      smask = (64'd1 << s) - 1;
      k = n;
      found = 1'b0;
      for (int i = 1; i <= n; i++) begin
         if (!found && (((ux >> ((n - i) * s)) & smask) != ((uy >> ((n - i) * s)) & smask))) begin
            k = i;
            found = 1'b1;
         end
      end
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int W = CW[g];
      localparam int S = CS[g];

      logic         rst, start, sm, busy, done;
      logic [W-1:0] a, b;
      logic [2:0]   out;

      mag_cmp_seq #(.WIDTH(W), .SLICE(S)) dut (
         .clk         (clk),
         .rst         (rst),
         .start       (start),
         .a           (a),
         .b           (b),
         .signed_mode (sm),
         .busy        (busy),
         .done        (done),
         .out         (out)
      );

      // Compare process: outputs checked each cycle, then the model steps on the inputs
      // that the next rising edge will sample.
      initial begin
         int         left;
         bit         mdone, mvalid, nd;
         logic [2:0] mout, mpend, eo;
         int         ek;
         left = 0;
         mdone = 1'b0;
         mvalid = 1'b0;
         mout = 3'b000;
         mpend = 3'b000;
         forever begin
            @(negedge clk);
            if (mvalid) begin
               check($sformatf("c%0d_busy", g), 64'(busy), 64'(left > 0));
               check($sformatf("c%0d_done", g), 64'(done), 64'(mdone));
               check($sformatf("c%0d_out", g), 64'(out), 64'(mout));
            end
            if (rst === 1'b1) begin
               left = 0;
               mdone = 1'b0;
               mout = 3'b000;
               mvalid = 1'b1;
            end else if (mvalid) begin
               nd = 1'b0;
               if (left > 0) begin
                  left--;
                  if (left == 0) begin
                     nd = 1'b1;
                     mout = mpend;
                  end
               end else if (start) begin
                  ref_cmp(64'(a), 64'(b), W, S, sm, eo, ek);
                  mpend = eo;
                  left = ek;
               end
               mdone = nd;
            end
         end
      end

      task automatic do_reset();
         rst = 1'b1;
         start = 1'b0;
         sm = 1'b0;
         a = '0;
         b = '0;
         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
      endtask

      // One compare: returns accept-to-done latency, busy cycle count and the result.
      task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input bit sg,
                         output int lat, output int bc, output logic [2:0] o);
         @(posedge clk);
         #1;
         a = x;
         b = y;
         sm = sg;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         bc = int'(busy);
         lat = 0;
         while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done) bc += int'(busy);
         end
         check($sformatf("c%0d_done_seen", g), 64'(done), 64'd1);
         o = out;
      endtask

      task automatic rand_sweep();
         logic [63:0] r1, r2, y64;
         int          pos, lat, bc;
         logic [2:0]  o;
         for (int i = 0; i < 1000; i++) begin
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            case ($urandom_range(0, 4))
               0: y64 = r2;
               1: y64 = r1;
               2: begin
                  pos = int'($urandom_range(0, W - 1));
                  y64 = r1 ^ ((r2 & ((64'd1 << pos) - 1)) | (64'd1 << pos));
               end
               3: y64 = r1 ^ (64'd1 << (W - 1));
               default: y64 = r1 ^ 64'd1;
            endcase
            run(r1[W-1:0], y64[W-1:0], 1'($urandom_range(0, 1)), lat, bc, o);
         end
      endtask

      if (g == 0) begin : g_dir
         initial begin
            int         lat, bc, np;
            logic [2:0] o;
            do_reset();
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_out", 64'(out), 64'd0);

            run(16'h1234, 16'h1234, 1'b0, lat, bc, o);
            check("eq_lat", 64'(lat), 64'd4);
            check("eq_busy_cycles", 64'(bc), 64'd4);
            check("eq_out", 64'(o), 64'b010);

            run(16'hA000, 16'h9FFF, 1'b0, lat, bc, o);
            check("early_gt_lat", 64'(lat), 64'd1);
            check("early_gt_out", 64'(o), 64'b100);
            run(16'h12F0, 16'h1300, 1'b0, lat, bc, o);
            check("early_lt_lat", 64'(lat), 64'd2);
            check("early_lt_out", 64'(o), 64'b001);

            run(16'hFFFF, 16'h0001, 1'b0, lat, bc, o);
            check("uns_ffff_out", 64'(o), 64'b100);
            run(16'hFFFF, 16'h0001, 1'b1, lat, bc, o);
            check("sgn_ffff_out", 64'(o), 64'b001);
            run(16'h8000, 16'h7FFF, 1'b1, lat, bc, o);
            check("sgn_8000_out", 64'(o), 64'b001);

            // start pulsed mid-compare, operands changed while busy
            @(posedge clk);
            #1;
            a = 16'h1234;
            b = 16'h1234;
            sm = 1'b0;
            start = 1'b1;
            @(posedge clk);
            #1;
            a = 16'h0000;
            b = 16'hFFFF;
            @(posedge clk);
            #1;
            start = 1'b0;
            a = 16'hFFFF;
            b = 16'h0000;
            sm = 1'b1;
            np = 0;
            o = 3'b000;
            repeat (8) begin
               @(posedge clk);
               #1;
               np += int'(done);
               if (done) o = out;
            end
            check("mid_start_pulses", 64'(np), 64'd1);
            check("mid_start_out", 64'(o), 64'b010);
            check("held_out_idle", 64'(out), 64'b010);

            // start held through DONE: second compare follows with no idle cycle
            @(posedge clk);
            #1;
            a = 16'hA000;
            b = 16'h9FFF;
            sm = 1'b0;
            start = 1'b1;
            @(posedge clk);
            #1;
            a = 16'h12F0;
            b = 16'h1300;
            @(posedge clk);
            #1;
            check("b2b_first_done", 64'(done), 64'd1);
            check("b2b_first_out", 64'(out), 64'b100);
            @(posedge clk);
            #1;
            check("b2b_second_busy", 64'(busy), 64'd1);
            check("b2b_second_nodone", 64'(done), 64'd0);
            start = 1'b0;
            @(posedge clk);
            #1;
            check("b2b_second_busy2", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            check("b2b_second_done", 64'(done), 64'd1);
            check("b2b_second_out", 64'(out), 64'b001);

            // reset in the second CMP cycle aborts the compare
            @(posedge clk);
            #1;
            a = 16'h1234;
            b = 16'h1234;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_done", 64'(done), 64'd0);
            check("abort_out", 64'(out), 64'd0);
            np = 0;
            repeat (8) begin
               @(posedge clk);
               #1;
               np += int'(done);
            end
            check("abort_no_pulse", 64'(np), 64'd0);
            run(16'h0001, 16'h0002, 1'b1, lat, bc, o);
            check("post_rst_lat", 64'(lat), 64'd4);
            check("post_rst_out", 64'(o), 64'b001);

            rand_sweep();
            fin_v[g] = 1'b1;
         end
      end else begin : g_rnd
         initial begin
            do_reset();
            rand_sweep();
            fin_v[g] = 1'b1;
         end
      end
   end

   initial begin
      int cyc;
      bit af;
      cyc = 0;
      af = 1'b0;
      while (!af && cyc < 80000) begin
         @(posedge clk);
         cyc++;
         af = 1'b1;
         for (int i = 0; i < NCFG; i++) af &= fin_v[i];
      end
      check("all_configs_finished", 64'(af), 64'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mag_cmp_seq.md
# mag_cmp_seq

Parametrised, multi-cycle magnitude comparator that replaces the fixed 4-bit gate-level comparator. It compares two WIDTH-bit operands SLICE bits per cycle, MSB slice first, stops at the first differing slice, and supports unsigned and two's-complement modes. It is used wherever the datapath needs a {gt, eq, lt} flag triple without a full-width comparator in one cycle, for example branch condition evaluation. A start/busy/done handshake controls each compare, and the result is held until the next start.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2 and a multiple of SLICE
- SLICE, 4, bits compared per cycle; 1 ≤ SLICE ≤ WIDTH; N = WIDTH/SLICE slices
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare; accepted only when busy=0
- a  input  WIDTH  operand A; sampled on the accepting edge only
- b  input  WIDTH  operand B; sampled on the accepting edge only
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when out is updated
- out  output  3  {gt, eq, lt}, one-hot after the first compare; relation of A to B

## Operation
- FSM states:
  - IDLE (reset state)
  - CMP
  - DONE
- IDLE or DONE, start=1:
  - capture a and b into internal registers
  - if signed_mode=1, invert bit WIDTH-1 of both captured copies; an unsigned compare of the result is then the signed compare
  - set slice index to N-1
  - go to CMP
- IDLE, start=0: stay. DONE, start=0: go to IDLE.
- CMP, each cycle, evaluate slice [idx*SLICE +: SLICE]:
  - slices differ: out ← {A>B, 0, A<B} for that slice; go to DONE
  - slices equal and idx=0: out ← 3'b010; go to DONE
  - slices equal and idx>0: idx ← idx−1; stay in CMP
- busy = 1 exactly in CMP. done = 1 exactly in DONE.
- start while in CMP is ignored; no queuing.
- out changes only on the transition into DONE (and on reset). It holds otherwise, including through later IDLE cycles.
- Changing a, b or signed_mode after acceptance has no effect on the compare in progress.
- Reset values: state=IDLE, busy=0, done=0, out=3'b000 ("no result yet"), idx=N-1, operand registers=0.
- rst takes priority over everything, including a compare in progress: the compare is aborted, no done pulse is issued, and all outputs go to reset values on the next edge.

## Timing
- Start accepted at edge E0. The first differing slice is the k-th from MSB (k = 1..N), or k = N if the operands are equal.
- The CMP cycles occupy edges E0..E(k−1). busy is high during those k cycles.
- done and the new out are visible after edge Ek, and done stays high for exactly one cycle.
- Latency from accept to done: k cycles. Minimum 1 cycle, maximum N cycles.
- Back-to-back: start held high during the DONE cycle is accepted. Throughput is one compare per k+1 cycles.
- out is registered: there is no combinational path from a, b or start to out, done or busy.

## Test plan
- Equal operands: WIDTH=16, SLICE=4, a=b=16'h1234, unsigned → busy high 4 cycles, done pulse 4 cycles after accept, out=3'b010.
- Early termination: a=16'hA000, b=16'h9FFF, unsigned → out=3'b100 with done 1 cycle after accept. Then a=16'h12F0, b=16'h1300 → out=3'b001 with done 2 cycles after accept.
- Signed vs unsigned: a=16'hFFFF, b=16'h0001 → signed_mode=0 gives out=3'b100; signed_mode=1 gives out=3'b001. Also a=16'h8000, b=16'h7FFF, signed → out=3'b001.
- Handshake:
  - start pulsed mid-compare with different operands → ignored; the original result is produced, and exactly one done pulse is issued
  - a and b changed while busy → result unaffected
  - start held high through DONE → second compare begins with no idle gap
- Reset: rst asserted at the 2nd CMP cycle of an equal-operand compare → next cycle busy=0, done=0, out=3'b000, and no done pulse appears afterwards. A subsequent compare works normally.
- Parameter sweep: (WIDTH, SLICE) ∈ {(16,1), (16,16), (32,8), (8,2)}, 1000 random signed and unsigned pairs plus directed MSB/LSB-only differences. Check against a reference model on every done; check latency equals the index of the first differing slice (k).
